// File: rtl/adder_imm_pkg.sv
// Shared constants and address type for the adder_imm block.
package adder_imm_pkg;

  localparam int ADDR_WIDTH       = 32;
  localparam int ADDR_ALIGN_BITS  = 2;

  typedef logic [ADDR_WIDTH-1:0] addr_t;

endpackage

// File: rtl/adder_imm_core.sv
// Combinational target adder: sum, unsigned carry and low-bit alignment flag.
// Alignment logic exists only when ADDER_IMM_ALIGN_CHECK_EN is defined.
module adder_imm_core
  import adder_imm_pkg::*;
#(
  parameter int WIDTH      = ADDR_WIDTH,
  parameter int ALIGN_BITS = ADDR_ALIGN_BITS
) (
  input  logic [WIDTH-1:0] PC,
  input  logic [WIDTH-1:0] immediate_data,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             misaligned
);

  if (ALIGN_BITS < 1 || ALIGN_BITS > WIDTH) begin : g_bad_align
    $error("adder_imm_core: ALIGN_BITS must be within 1..WIDTH");
  end

  // One extra bit captures the unsigned carry; signed immediates wrap naturally.
  always_comb begin
    {carry, sum} = {1'b0, PC} + {1'b0, immediate_data};
  end

`ifdef ADDER_IMM_ALIGN_CHECK_EN
  assign misaligned = |sum[ALIGN_BITS-1:0];
`else
  assign misaligned = 1'b0;
`endif

endmodule

// File: rtl/adder_imm.sv
// Branch/jump target adder with registered copies of target and alignment flag.
// Optional alignment check: ADDER_IMM_ALIGN_CHECK_EN.
module adder_imm
  import adder_imm_pkg::*;
#(
  parameter int WIDTH      = ADDR_WIDTH,
  parameter int ALIGN_BITS = ADDR_ALIGN_BITS
) (
  input  logic [WIDTH-1:0] PC,
  input  logic [WIDTH-1:0] immediate_data,
  output logic [WIDTH-1:0] PCTarget,
  input  logic             clk,
  input  logic             rst,
  output logic             carry_out,
  output logic             misaligned,
  output logic [WIDTH-1:0] PCTarget_q,
  output logic             misaligned_q
);

  adder_imm_core #(
    .WIDTH      (WIDTH),
    .ALIGN_BITS (ALIGN_BITS)
  ) u_core (
    .PC             (PC),
    .immediate_data (immediate_data),
    .sum            (PCTarget),
    .carry          (carry_out),
    .misaligned     (misaligned)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      PCTarget_q <= '0;
    end else begin
      PCTarget_q <= PCTarget;
    end
  end

`ifdef ADDER_IMM_ALIGN_CHECK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      misaligned_q <= 1'b0;
    end else begin
      misaligned_q <= misaligned;
    end
  end
`else
  assign misaligned_q = 1'b0;
`endif

endmodule

// File: tb/tb_adder_imm.sv
// Directed, table-driven bench for adder_imm; follows ADDER_IMM_ALIGN_CHECK_EN.
module tb_adder_imm;
  import adder_imm_pkg::*;

`ifdef ADDER_IMM_ALIGN_CHECK_EN
  localparam bit ALIGN_EN = 1'b1;
`else
  localparam bit ALIGN_EN = 1'b0;
`endif

  logic        clk;
  logic        rst;
  addr_t       pc;
  addr_t       imm;
  addr_t       pc_target;
  logic        carry_out;
  logic        misaligned;
  addr_t       pc_target_q;
  logic        misaligned_q;

  int checks   = 0;
  int failures = 0;

  adder_imm dut (
    .PC             (pc),
    .immediate_data (imm),
    .PCTarget       (pc_target),
    .clk            (clk),
    .rst            (rst),
    .carry_out      (carry_out),
    .misaligned     (misaligned),
    .PCTarget_q     (pc_target_q),
    .misaligned_q   (misaligned_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] imm;
    logic [31:0] target;
    logic        carry;
    logic        mis_raw;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  vec_t vecs[12];

  initial begin
    vecs[0]  = '{32'd50,        32'd10,        32'd60,          1'b0, 1'b0};
    vecs[1]  = '{32'd25,        32'd10,        32'd35,          1'b0, 1'b1};
    vecs[2]  = '{32'd25,        32'd50,        32'd75,          1'b0, 1'b1};
    vecs[3]  = '{32'd90,        32'd50,        32'd140,         1'b0, 1'b0};
    vecs[4]  = '{32'd90,        32'd125,       32'd215,         1'b0, 1'b1};
    vecs[5]  = '{32'd1002,      32'd125,       32'd1127,        1'b0, 1'b1};
    vecs[6]  = '{32'd1002,      32'd12,        32'd1014,        1'b0, 1'b1};
    vecs[7]  = '{32'hFFFF_FFFC, 32'd8,         32'd4,           1'b1, 1'b0};
    vecs[8]  = '{32'd100,       32'hFFFF_FFF8, 32'd92,          1'b1, 1'b0};
    vecs[9]  = '{32'hFFFF_FFFF, 32'd1,         32'd0,           1'b1, 1'b0};
    vecs[10] = '{32'h7FFF_FFFF, 32'd1,         32'h8000_0000,   1'b0, 1'b0};
    vecs[11] = '{32'd0,         32'd0,         32'd0,           1'b0, 1'b0};

    // Reset state, with the combinational path live during reset
    rst = 1'b1;
    pc  = 32'd50;
    imm = 32'd10;
    #1;
    check("reset_target_q", pc_target_q, 32'd0);
    check("reset_mis_q", {31'd0, misaligned_q}, 32'd0);
    check("reset_comb_target", pc_target, 32'd60);
    check("reset_comb_carry", {31'd0, carry_out}, 32'd0);
    @(posedge clk); #1;
    check("reset_hold_target_q", pc_target_q, 32'd0);

    // First edge after release loads directly
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    check("release_first_edge_q", pc_target_q, 32'd60);

    // Asynchronous reset mid-run, away from any edge
    rst = 1'b1;
    #1;
    check("async_reset_q", pc_target_q, 32'd0);
    check("async_reset_comb", pc_target, 32'd60);
    rst = 1'b0;
    @(posedge clk); #1;
    check("post_reset_reload_q", pc_target_q, 32'd60);

    // Input change between edges: comb follows, registers wait for edge
    @(negedge clk);
    pc = 32'd25;
    #1;
    check("between_edges_comb", pc_target, 32'd35);
    check("between_edges_comb_mis", {31'd0, misaligned}, {31'd0, ALIGN_EN});
    check("between_edges_hold_q", pc_target_q, 32'd60);
    check("between_edges_hold_mis_q", {31'd0, misaligned_q}, 32'd0);
    @(posedge clk); #1;
    check("next_edge_q", pc_target_q, 32'd35);
    check("next_edge_mis_q", {31'd0, misaligned_q}, {31'd0, ALIGN_EN});

    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      pc  = vecs[i].pc;
      imm = vecs[i].imm;
      #1;
      check($sformatf("vec%0d_target", i), pc_target, vecs[i].target);
      check($sformatf("vec%0d_carry", i), {31'd0, carry_out}, {31'd0, vecs[i].carry});
      check($sformatf("vec%0d_mis", i), {31'd0, misaligned},
            {31'd0, vecs[i].mis_raw & ALIGN_EN});
      @(posedge clk); #1;
      check($sformatf("vec%0d_target_q", i), pc_target_q, vecs[i].target);
      check($sformatf("vec%0d_mis_q", i), {31'd0, misaligned_q},
            {31'd0, vecs[i].mis_raw & ALIGN_EN});
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
